uart_rx: RTL

Serial-to-parallel UART receiver, the downstream partner of the transmitter in the same UART block. It samples an asynchronous serial line with CLKS_PER_BIT clocks per bit and recovers 8N1 frames: one low start bit, eight data bits LSB first, one high stop bit. Each received byte is presented on a parallel output with a one-cycle valid pulse. It sits between the board-level RX pin (or a loopback of the transmitter's data_out) and the consuming logic.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_if.sv | 14 +
 rtl/uart_sync.sv | 27 ++
 rtl/uart_rx.sv | 105 ++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit timing, frame width.
// Pure constants and types; no latency, no backpressure.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_e;

  localparam int CLKS_PER_BIT_DEF = 16;
  localparam int DATA_BITS        = 8;

endpackage

// File: rtl/uart_rx_if.sv
// Parallel side of the receiver: byte, valid/error pulses, busy flag.
// Pulses are single-cycle with no backpressure; the consumer samples them as they come.
interface uart_rx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 frame_err;
  logic                 busy;

  modport master (output data_out, data_valid, frame_err, busy);
  modport slave  (input  data_out, data_valid, frame_err, busy);

endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer for asynchronous inputs, reset to all-ones (idle line level).
// Latency 2 clk cycles; no backpressure.
module uart_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: pulse CLKS_PER_BIT/2+9*CLKS_PER_BIT cycles after the detected start edge.
// No backpressure: data_valid/frame_err are one-cycle pulses, data_out holds until the next good frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rx_in,
  uart_rx_if.master rx_if
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  uart_state_e          state_q;
  logic [CW-1:0]        cnt_q;
  logic [2:0]           bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 dv_q;
  logic                 fe_q;
  logic                 rx_prev_q;
  logic                 rx_s;

  uart_sync #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx_in),
    .q_o   (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      dv_q      <= 1'b0;
      fe_q      <= 1'b0;
      rx_prev_q <= 1'b1;
    end else begin
      rx_prev_q <= rx_s;
      dv_q      <= 1'b0;
      fe_q      <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          // Edge-triggered so a line held low (break) never retriggers.
          if (rx_prev_q && !rx_s) state_q <= START;
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q <= '0;
            if (!rx_s) begin
              bit_idx_q <= '0;
              state_q   <= DATA;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q            <= '0;
            shift_q[bit_idx_q] <= rx_s;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            if (rx_s) begin
              data_q <= shift_q;
              dv_q   <= 1'b1;
            end else begin
              fe_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_if.data_out   = data_q;
  assign rx_if.data_valid = dv_q;
  assign rx_if.frame_err  = fe_q;
  assign rx_if.busy       = (state_q != IDLE);

endmodule
